instr_stream_encoder: RTL
=========================

# instr_stream_encoder

Loads programs into the pipeline's instruction memory. It accepts decoded operation descriptors over a valid/ready handshake and encodes each one into a 32-bit RV32I instruction word. It then writes the words into instruction memory at consecutive word addresses. It covers exactly the instruction classes the pipeline's control decoder recognises (R, I-ALU, LW, SW, BEQ, JAL, JALR), plus a NOP, and is used by boot/test infrastructure ahead of the fetch stage.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width.
- `BASE_ADDR`, 0: first word address written after `start`.
- `DEPTH`, 256: maximum words per session; requires `DEPTH <= 2**ADDR_W`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; opens a load session.
- `in_valid`  in  1  descriptor valid.
- `in_ready`  out  1  encoder can accept a descriptor.
- `in_op`  in  3  op class: 0 R, 1 I-ALU, 2 LW, 3 SW, 4 BEQ, 5 JAL, 6 JALR, 7 NOP.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_func3`  in  3  func3; used for R and I-ALU only.
- `in_alt`  in  1  func7[5]: SUB/SRA for R, SRAI for I-ALU with func3=101.
- `in_imm`  in  32  signed immediate; byte offset for BEQ and JAL.
- `in_last`  in  1  final descriptor of the session.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  encoded instruction.
- `busy`  out  1  session active.
- `done`  out  1  session complete; held until `start` or `rst`.
- `count`  out  ADDR_W+1  words written this session.
- `err`  out  1  sticky immediate-range error; see Configuration.

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE.
  - IDLE → ACCEPT on `start`.
  - ACCEPT → WRITE on handshake (`in_valid & in_ready`).
  - WRITE → DONE if the accepted beat had `in_last`, or if `count` reaches `DEPTH` after this write; otherwise WRITE → ACCEPT.
  - DONE → ACCEPT on `start`.
- `in_ready` = 1 only in ACCEPT. Descriptor fields are captured on the handshake edge only.
- `start` in any state clears `count` and `err`, clears `done`, and enters ACCEPT. A `start` coincident with a handshake discards that descriptor.
- `imem_addr` = (`BASE_ADDR` + `count`) mod 2**`ADDR_W`, so the address wraps silently. `count` increments on each WRITE cycle.
- Encoding:
  - R: {alt?0100000:0000000, rs2, rs1, f3, rd, 0110011}.
  - I-ALU: {imm[11:0], rs1, f3, rd, 0010011}. For f3=001 or 101, bits[31:25] = (f3==101 & alt)?0100000:0000000 and bits[24:20] = imm[4:0].
  - LW: {imm[11:0], rs1, 010, rd, 0000011}.
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - BEQ: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
  - JALR: {imm[11:0], rs1, 000, rd, 1100111}.
  - NOP: 0x00000013.
- Immediate bits not listed for an op class are ignored. Unused register fields are ignored.

## Timing
- Reset values: state IDLE; `in_ready`, `imem_we`, `busy`, `done`, `err` = 0; `count` = 0; `imem_addr` = 0; `imem_wdata` = 0.
- `rst` mid-session aborts the session. Any pending write is dropped and no `imem_we` is issued after the reset edge.
- All outputs are registered.
- `busy` = 1 in ACCEPT and WRITE.
- Handshake at edge N → `imem_we`=1 with valid `imem_addr`/`imem_wdata` during cycle N+1.
  - Earliest next handshake is edge N+2, giving throughput of one word per 2 cycles.
- `done` rises in the cycle after the last WRITE. `in_ready` is 0 from that point.

## Configuration
- `INSTR_ENC_RANGE_CHECK_EN` defined: `err` is set in the WRITE cycle of an out-of-range immediate, and stays set until `start` or `rst`. A descriptor is out of range when:
  - I-ALU, LW, SW, JALR: `in_imm` does not fit signed 12 bits.
  - I-ALU shifts: `in_imm` is outside 0..31.
  - BEQ: `in_imm` does not fit signed 13 bits, or bit0 = 1.
  - JAL: `in_imm` does not fit signed 21 bits, or bit0 = 1.
- In all range-error cases the truncated word is still written.
- Undefined: no check logic is built, `err` is tied 0, and truncation is silent.

## Structure
- Package `instr_enc_pkg`:
  - op-class codes 0–7.
  - 7-bit opcode constants (OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_JALR).
  - NOP word constant.
  - FSM state encoding.
- Sub-module `instr_word_enc`: purely combinational. Takes the captured descriptor and produces the 32-bit word, plus `range_err` when the macro is enabled. The top level holds the FSM, counter, and registers.

## Test plan
- Descriptor R, rd=3, rs1=1, rs2=2, f3=000, alt=1, `in_last`=1 → one write of 0x402081B3 at addr 0, then `done`=1, `count`=1.
- Sequence LW rd=5 rs1=2 imm=8; SW rs2=5 rs1=2 imm=12 → writes 0x00812283 @0 and 0x00512623 @1. `in_valid` held high throughout shows `in_ready` alternating 1/0.
- BEQ rs1=1 rs2=2 imm=-4; JAL rd=1 imm=8 → 0xFE208EE3 and 0x008000EF.
- `DEPTH`=4, `BASE_ADDR`=254, `ADDR_W`=8, 5 beats without `in_last` → writes at 254, 255, 0, 1; `done` after the 4th write; 5th beat never accepted.
- I-ALU rd=0 rs1=0 imm=2048 → word 0x80000013. `err`=1 with the macro, 0 without. A following `start` clears `err`.
- `rst` asserted in the cycle between the handshake and WRITE → no `imem_we`, all outputs at reset values.

Source files
------------

// File: rtl/instr_stream_encoder_pkg.sv
// Purpose: shared op-class codes, RV32I opcodes, NOP word, FSM encoding and descriptor type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_enc_pkg;

    localparam logic [2:0] OPC_R    = 3'd0;
    localparam logic [2:0] OPC_I    = 3'd1;
    localparam logic [2:0] OPC_LW   = 3'd2;
    localparam logic [2:0] OPC_SW   = 3'd3;
    localparam logic [2:0] OPC_BEQ  = 3'd4;
    localparam logic [2:0] OPC_JAL  = 3'd5;
    localparam logic [2:0] OPC_JALR = 3'd6;
    localparam logic [2:0] OPC_NOP  = 3'd7;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCEPT = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  func3;
        logic        alt;
        logic [31:0] imm;
    } desc_t;

endpackage

// File: rtl/instr_stream_encoder_if.sv
// Purpose: descriptor stream in, instruction-memory write port out.
// Latency: n/a (wiring only).
// Backpressure: in_ready gates the descriptor stream; the write port has none.
interface instr_stream_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_func3;
    logic              in_alt;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_func3, in_alt, in_imm, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_func3, in_alt, in_imm, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_stream_encoder_word_enc.sv
// Purpose: combinational RV32I encoder for one descriptor; range_err only with INSTR_ENC_RANGE_CHECK_EN.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module instr_word_enc
    import instr_enc_pkg::*;
(
    input  desc_t       desc,
    output logic [31:0] word
`ifdef INSTR_ENC_RANGE_CHECK_EN
    ,
    output logic        range_err
`endif
);
    logic [31:0] imm;
    logic        is_shift;

    assign imm      = desc.imm;
    assign is_shift = (desc.func3 == 3'b001) || (desc.func3 == 3'b101);

    always_comb begin
        word = NOP_WORD;
        case (desc.op)
            OPC_R:    word = {1'b0, desc.alt, 5'b0, desc.rs2, desc.rs1, desc.func3, desc.rd, OP_R};
            OPC_I: begin
                if (is_shift)
                    word = {1'b0, (desc.func3 == 3'b101) && desc.alt, 5'b0, imm[4:0],
                            desc.rs1, desc.func3, desc.rd, OP_I};
                else
                    word = {imm[11:0], desc.rs1, desc.func3, desc.rd, OP_I};
            end
            OPC_LW:   word = {imm[11:0], desc.rs1, 3'b010, desc.rd, OP_LW};
            OPC_SW:   word = {imm[11:5], desc.rs2, desc.rs1, 3'b010, imm[4:0], OP_SW};
            OPC_BEQ:  word = {imm[12], imm[10:5], desc.rs2, desc.rs1, 3'b000, imm[4:1], imm[11], OP_BEQ};
            OPC_JAL:  word = {imm[20], imm[10:1], imm[11], imm[19:12], desc.rd, OP_JAL};
            OPC_JALR: word = {imm[11:0], desc.rs1, 3'b000, desc.rd, OP_JALR};
            default:  word = NOP_WORD;
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic fits12, fits13, fits21;
    assign fits12 = (imm[31:11] == {21{imm[11]}});
    assign fits13 = (imm[31:12] == {20{imm[12]}});
    assign fits21 = (imm[31:20] == {12{imm[20]}});

    always_comb begin
        range_err = 1'b0;
        case (desc.op)
            OPC_I:    range_err = is_shift ? (|imm[31:5]) : !fits12;
            OPC_LW, OPC_SW, OPC_JALR: range_err = !fits12;
            OPC_BEQ:  range_err = !fits13 || imm[0];
            OPC_JAL:  range_err = !fits21 || imm[0];
            default:  range_err = 1'b0;
        endcase
    end
`else
    // High immediate bits only matter to the range check.
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:21];
`endif

endmodule

// File: rtl/instr_stream_encoder.sv
// Purpose: encodes descriptors into RV32I words and writes them to consecutive imem addresses; INSTR_ENC_RANGE_CHECK_EN adds err.
// Latency: handshake at edge N gives imem_we with addr/data during cycle N+1; one word per 2 cycles.
// Backpressure: in_ready high only in ACCEPT; deasserted during WRITE and once the session completes.
module instr_stream_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    instr_stream_encoder_if.slave  bus,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W:0]        count,
    output logic                   err
);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic              hs;
    logic [ADDR_W:0]   count_inc;
    desc_t             desc;
    logic [31:0]       word;

    assign desc = '{op: bus.in_op, rd: bus.in_rd, rs1: bus.in_rs1, rs2: bus.in_rs2,
                    func3: bus.in_func3, alt: bus.in_alt, imm: bus.in_imm};

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic range_err;
    logic err_q, err_d;

    instr_word_enc u_enc (.desc(desc), .word(word), .range_err(range_err));
`else
    instr_word_enc u_enc (.desc(desc), .word(word));
`endif

    assign hs        = bus.in_valid && (state_q == ST_ACCEPT);
    assign count_inc = count_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_ACCEPT: begin
                if (hs) begin
                    state_d = ST_WRITE;
                    wdata_d = word;
                    last_d  = bus.in_last;
`ifdef INSTR_ENC_RANGE_CHECK_EN
                    // Set on capture so err is already visible during the WRITE cycle.
                    err_d   = err_q || range_err;
`endif
                end
            end
            ST_WRITE: begin
                count_d = count_inc;
                addr_d  = addr_q + ADDR_W'(1);
                state_d = (last_q || (count_inc == DEPTH_C)) ? ST_DONE : ST_ACCEPT;
            end
            default: state_d = state_q;
        endcase
        // start overrides everything, including a coincident handshake.
        if (start) begin
            state_d = ST_ACCEPT;
            count_d = '0;
            addr_d  = BASE_C;
            last_d  = 1'b0;
`ifdef INSTR_ENC_RANGE_CHECK_EN
            err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
        end
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign bus.in_ready   = (state_q == ST_ACCEPT);
    assign bus.imem_we    = (state_q == ST_WRITE);
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
    assign done           = (state_q == ST_DONE);
    assign count          = count_q;

endmodule
